ov7670_capture: RTL and testbench

- Upstream feeder of the SPRAM frame buffer (17-bit byte address, 8-bit data, write enable).
- Samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]) in YUV422 order Y0 U0 Y1 V0 ... and keeps only the luma bytes.
- Writes one frame of luma into the buffer as a linear raster; the JPEG path can then read it.
- Frames are captured on request, single-shot or continuous, and the block reports done and error status.

---
 rtl/ov7670_pkg.sv | 20 ++
 rtl/ov7670_sync_edge.sv | 37 +++
 rtl/ov7670_capture.sv | 160 ++++++++++++++++
 tb/tb_ov7670_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and default geometry for the OV7670 luma capture path.
// The state enum and byte-order constant are used by the capture top.
package ov7670_pkg;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  localparam int ADDR_W_DEF   = 17;

  // 1 = the first byte after an HREF rise is luma (Y0 U0 Y1 V0 ...).
  localparam bit Y_FIRST_DEF  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_VBLANK,
    ST_ACTIVE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ov7670_sync_edge.sv
// Registers camera VSYNC/HREF once and flags their edges against the live
// input, so an edge is seen in the same cycle the new level arrives.
module ov7670_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  input  logic href,
  output logic vs_rise,
  output logic vs_fall,
  output logic href_fall
);

  logic vs_q, vs_d;
  logic href_q, href_d;

  always_comb begin
    vs_d   = vsync;
    href_d = href;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q   <= 1'b0;
      href_q <= 1'b0;
    end else begin
      vs_q   <= vs_d;
      href_q <= href_d;
    end
  end

  assign vs_rise   =  vsync & ~vs_q;
  assign vs_fall   = ~vsync &  vs_q;
  assign href_fall = ~href  &  href_q;

endmodule

// File: rtl/ov7670_capture.sv
// Captures one frame of OV7670 luma into a linear raster buffer, single-shot
// or continuous, and reports frame completion and geometry errors.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit Y_FIRST  = Y_FIRST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);

  localparam logic [COL_W-1:0]  H_MAX      = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_MAX      = LINE_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP     = ADDR_W'(H_ACTIVE);
  localparam logic              LUMA_PHASE = ~Y_FIRST;

  logic vs_rise, vs_fall, href_fall;

  ov7670_sync_edge u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .vsync     (cam_vsync),
    .href      (cam_href),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .href_fall (href_fall)
  );

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                phase_q, phase_d;
  logic                err_q, err_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;

  logic in_active, byte_ok, line_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      line_q    <= '0;
      base_q    <= '0;
      phase_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      line_q    <= line_d;
      base_q    <= base_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start)   state_d = ST_SYNC;
      ST_SYNC:   if (vs_rise) state_d = ST_VBLANK;
      ST_VBLANK: if (vs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (vs_rise) state_d = ST_DONE;
      ST_DONE:   state_d = continuous ? ST_VBLANK : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A vsync rise with href still high closes the line instead of storing a byte.
  assign in_active = (state_q == ST_ACTIVE);
  assign byte_ok   = in_active && cam_href && !vs_rise;
  assign line_end  = in_active && (href_fall || (vs_rise && cam_href));

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    col_d     = col_q;
    line_d    = line_q;
    base_d    = base_q;
    phase_d   = phase_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (state_q == ST_IDLE && start) err_d = 1'b0;

    if (state_q == ST_VBLANK && vs_fall) begin
      col_d   = '0;
      line_d  = '0;
      base_d  = '0;
      phase_d = 1'b0;
      err_d   = 1'b0;
    end

    if (byte_ok) begin
      phase_d = ~phase_q;
      if (phase_q == LUMA_PHASE) begin
        if (col_q < H_MAX) begin
          if (line_q < V_MAX) begin
            wr_en_d   = 1'b1;
            wr_data_d = cam_data;
            wr_addr_d = base_q + ADDR_W'(col_q);
          end
          col_d = col_q + COL_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (line_end) begin
      if (line_q < V_MAX) begin
        if (col_q != H_MAX) err_d = 1'b1;
        line_d = line_q + LINE_W'(1);
        base_d = base_q + H_STEP;
      end
      col_d   = '0;
      phase_d = 1'b0;
    end

    if (state_q == ST_DONE && line_q != V_MAX) err_d = 1'b1;
  end

  // The short-frame check is folded in combinationally so it is visible with frame_done.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_DONE);
    frame_err  = err_q | ((state_q == ST_DONE) && (line_q != V_MAX));
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture on a reduced 16x8 geometry so whole
// frames stay short; a write scoreboard checks every stored luma byte.
module tb_ov7670_capture;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 7;

  localparam int EV_NONE  = 0;
  localparam int EV_START = 1;
  localparam int EV_RESET = 2;

  logic          clk = 1'b0;
  logic          reset, cam_vsync, cam_href, start, continuous;
  logic [7:0]    cam_data;
  logic          busy, frame_done, frame_err, wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  always #5 clk = ~clk;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .Y_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .start      (start),
    .continuous (continuous),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t e_mon;

  int   wr_count, last_addr, max_addr, first_addr, done_count;
  logic err_at_done, busy_at_done, busy_after_done;
  bit   prev_done, watch_busy, busy_dropped;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: write addr %0d data %0d, no write expected", wr_addr, wr_data);
      end else begin
        e_mon = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), e_mon.addr);
        check("wr_data", 32'(wr_data), e_mon.data);
      end
      if (wr_count == 0) first_addr = int'(wr_addr);
      wr_count++;
      last_addr = int'(wr_addr);
      if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
    end
    if (prev_done) busy_after_done = busy;
    if (frame_done === 1'b1) begin
      done_count++;
      err_at_done  = frame_err;
      busy_at_done = busy;
    end
    prev_done = (frame_done === 1'b1);
    if (watch_busy && busy !== 1'b1) busy_dropped = 1'b1;
  end

  typedef struct {
    int n_lines;
    int n_pix;
    int odd_line;
    int odd_pix;
    int ev_line;
    int ev_kind;
    int exp_writes;
    bit exp_err;
    int exp_last;
  } frame_vec_t;

  frame_vec_t vecs[5];

  task automatic clear_stats();
    wr_count   = 0;
    max_addr   = 0;
    last_addr  = -1;
    first_addr = -1;
    done_count = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic vsync_pulse();
    @(negedge clk) cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk) cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_lines(input int n_lines, input int n_pix, input int odd_line,
                            input int odd_pix, input bit expect_wr,
                            input int ev_line, input int ev_kind);
    bit exp_on;
    int pix;
    exp_on = expect_wr;
    for (int l = 0; l < n_lines; l++) begin
      pix = (l == odd_line) ? odd_pix : n_pix;
      if (l == ev_line && ev_kind == EV_START) pulse_start();
      if (l == ev_line && ev_kind == EV_RESET) begin
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        @(negedge clk) reset = 1'b0;
        exp_on = 1'b0;
        pulse_start();
      end
      for (int b = 0; b < 2 * pix; b++) begin
        @(negedge clk);
        cam_href = 1'b1;
        if (b % 2 == 0) begin
          cam_data = 8'((l ^ (b / 2)) & 255);
          if (exp_on && l < V && b / 2 < H)
            exp_q.push_back('{l * H + b / 2, (l ^ (b / 2)) & 255});
        end else begin
          cam_data = 8'h80;
        end
      end
      @(negedge clk);
      cam_href = 1'b0;
      cam_data = 8'h00;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic run_vec(input frame_vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    clear_stats();
    pulse_start();
    vsync_pulse();
    send_lines(v.n_lines, v.n_pix, v.odd_line, v.odd_pix, 1'b1, v.ev_line, v.ev_kind);
    vsync_pulse();
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_err_at_done"}, 32'(err_at_done), 32'(v.exp_err));
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 1);
    check({tag, "_busy_after_done"}, 32'(busy_after_done), 0);
    check({tag, "_err_sticky"}, 32'(frame_err), 32'(v.exp_err));
    check({tag, "_writes"}, wr_count, v.exp_writes);
    check({tag, "_first_addr"}, first_addr, 0);
    check({tag, "_last_addr"}, last_addr, v.exp_last);
    check({tag, "_max_addr"}, max_addr, v.exp_last);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    // n_lines, n_pix, odd_line, odd_pix, ev_line, ev_kind, writes, err, last_addr
    vecs[0] = '{V,     H,     -1, 0,     -1, EV_NONE,  128, 1'b0, 127}; // nominal
    vecs[1] = '{V,     H,      5, H - 2,  7, EV_START, 126, 1'b1, 127}; // short line, start while busy
    vecs[2] = '{V + 2, H + 2, -1, 0,     -1, EV_NONE,  128, 1'b1, 127}; // too many, too long
    vecs[3] = '{V - 1, H,     -1, 0,     -1, EV_NONE,  112, 1'b1, 111}; // too few lines
    vecs[4] = '{V,     H,      0, H + 1, -1, EV_NONE,  128, 1'b1, 127}; // one long line

    reset = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    start = 1'b0; continuous = 1'b0;
    watch_busy = 1'b0; busy_dropped = 1'b0; prev_done = 1'b0;
    busy_after_done = 1'b0; err_at_done = 1'b0; busy_at_done = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Start arriving mid-frame: that frame is skipped, the next one is stored from 0.
    clear_stats();
    vsync_pulse();
    send_lines(V, H, -1, 0, 1'b0, 3, EV_START);
    check("midstart_no_writes", wr_count, 0);
    check("midstart_busy", 32'(busy), 1);
    vsync_pulse();
    send_lines(V, H, -1, 0, 1'b1, -1, EV_NONE);
    vsync_pulse();
    check("midstart_first_addr", first_addr, 0);
    check("midstart_writes", wr_count, 128);
    check("midstart_done", done_count, 1);
    check("midstart_err", 32'(err_at_done), 0);

    // Continuous capture of three frames, dropping continuous before the last end.
    clear_stats();
    continuous = 1'b1;
    pulse_start();
    vsync_pulse();
    watch_busy = 1'b1;
    busy_dropped = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_lines(V, H, -1, 0, 1'b1, -1, EV_NONE);
      if (k == 2) begin
        watch_busy = 1'b0;
        continuous = 1'b0;
      end
      vsync_pulse();
    end
    check("cont_done_count", done_count, 3);
    check("cont_busy_held", 32'(busy_dropped), 0);
    check("cont_writes", wr_count, 384);
    check("cont_busy_after_last", 32'(busy_after_done), 0);
    check("cont_busy_idle", 32'(busy), 0);
    check("cont_pending", exp_q.size(), 0);

    // Reset at line 4 aborts the frame; restart waits for a fresh VSYNC.
    clear_stats();
    pulse_start();
    vsync_pulse();
    send_lines(V, H, -1, 0, 1'b1, 4, EV_RESET);
    check("rstmid_writes_before", wr_count, 4 * H);
    vsync_pulse();
    check("rstmid_no_done", done_count, 0);
    send_lines(V, H, -1, 0, 1'b1, -1, EV_NONE);
    vsync_pulse();
    check("rstmid_writes_total", wr_count, 4 * H + 128);
    check("rstmid_done", done_count, 1);
    check("rstmid_err", 32'(err_at_done), 0);
    check("rstmid_last_addr", last_addr, 127);
    check("rstmid_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
